// File: rtl/video_stream_gen.sv
// Interlaced video source: reads a linear frame store and emits each frame as two
// fields with fixed front/back porch and inter-field gap timing.
module video_stream_gen #(
  parameter int H_ACTIVE   = 702,
  parameter int V_ACTIVE   = 288,
  parameter int PIX_DIV    = 8,
  parameter int LINE_FRONT = 1500,
  parameter int LINE_BACK  = 1884,
  parameter int FIELD_GAP  = 100000,
  parameter int MEM_AW     = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic              mem_rd,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              video_frame_valid,
  output logic              video_line_valid,
  output logic              video_data_valid,
  output logic [7:0]        video_data_out,
  output logic [19:0]       video_address,
  output logic              frame_done
);
  localparam int SW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  typedef enum logic [2:0] {S_IDLE, S_FRONT, S_ACTIVE, S_BACK, S_GAP} state_t;

  state_t            r_state, w_nxt;
  logic [31:0]       r_cnt;
  logic [SW-1:0]     r_slot;
  logic [9:0]        r_col;
  logic [8:0]        r_row;
  logic              r_field;
  logic [MEM_AW-1:0] r_linear;
  logic [7:0]        r_data;
  logic [19:0]       r_addr;
  logic              r_dv, r_done;

  logic w_front_end, w_back_end, w_gap_end, w_slot_end, w_line_end, w_row_last, w_capture;

  assign w_front_end = (r_state == S_FRONT) && (r_cnt == 32'(LINE_FRONT - 1));
  assign w_back_end  = (r_state == S_BACK)  && (r_cnt == 32'(LINE_BACK - 1));
  assign w_gap_end   = (r_state == S_GAP)   && (r_cnt == 32'(FIELD_GAP - 1));
  assign w_slot_end  = (r_state == S_ACTIVE) && (r_slot == SW'(PIX_DIV - 1));
  assign w_line_end  = w_slot_end && (r_col == 10'(H_ACTIVE - 1));
  assign w_row_last  = (r_row == 9'(V_ACTIVE - 1));
  // Read data is on the bus during slot cycle 1; registering it here presents it in cycle 2.
  assign w_capture   = (r_state == S_ACTIVE) && (r_slot == SW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:   if (enable)      w_nxt = S_FRONT;
      S_FRONT:  if (w_front_end) w_nxt = S_ACTIVE;
      S_ACTIVE: if (w_line_end)  w_nxt = S_BACK;
      S_BACK:   if (w_back_end)  w_nxt = w_row_last ? S_GAP : S_FRONT;
      S_GAP:    if (w_gap_end)   w_nxt = (!r_field || enable) ? S_FRONT : S_IDLE;
      default:                   w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_slot   <= '0;
      r_col    <= '0;
      r_row    <= '0;
      r_field  <= 1'b0;
      r_linear <= '0;
      r_data   <= '0;
      r_addr   <= '0;
      r_dv     <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      if (r_state == S_IDLE || w_nxt != r_state) r_cnt <= '0;
      else                                       r_cnt <= r_cnt + 32'd1;

      if (r_state == S_ACTIVE) r_slot <= w_slot_end ? '0 : r_slot + 1'b1;
      else                     r_slot <= '0;

      if (r_state != S_ACTIVE) r_col <= '0;
      else if (w_slot_end)     r_col <= r_col + 10'd1;

      // Field 1 continues from where field 0 stopped; only a frame restart rewinds it.
      if (w_slot_end)                r_linear <= r_linear + 1'b1;
      else if (w_gap_end && r_field) r_linear <= '0;

      if (w_back_end && !w_row_last) r_row <= r_row + 9'd1;
      else if (w_gap_end)            r_row <= '0;

      if (w_gap_end) r_field <= ~r_field;

      r_dv <= w_capture;
      if (w_capture) begin
        r_data <= mem_data;
        r_addr <= {r_row, r_field, r_col};
      end else if (w_gap_end && r_field && !enable) begin
        r_data <= '0;
        r_addr <= '0;
      end

      r_done <= w_back_end && w_row_last && r_field;
    end
  end

  assign mem_rd            = (r_state == S_ACTIVE) && (r_slot == '0);
  assign mem_addr          = r_linear;
  assign video_frame_valid = (r_state == S_FRONT) || (r_state == S_ACTIVE) || (r_state == S_BACK);
  assign video_line_valid  = (r_state == S_ACTIVE);
  assign video_data_valid  = r_dv;
  assign video_data_out    = r_data;
  assign video_address     = r_addr;
  assign frame_done        = r_done;
endmodule

// File: tb/tb_video_stream_gen.sv
// Bench for video_stream_gen with small timing parameters: a positional timing model
// predicts every output each cycle; run statistics pin the model to literal values.
module tb_video_stream_gen;
  localparam int H = 4, V = 3, D = 4, F = 5, B = 6, G = 10, AW = 19;
  localparam int LP = F + H * D + B;   // line period
  localparam int FP = V * LP;          // frame_valid high per field
  localparam int FL = FP + G;          // field slot including gap
  localparam int FRAME = 2 * FL;
  localparam int NPIX = 2 * V * H;

  logic          clk = 1'b0, rst = 1'b0, enable = 1'b0;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data = 8'd0;
  logic          fv, lv, dvs, done;
  logic [7:0]    dout;
  logic [19:0]   vaddr;

  video_stream_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .PIX_DIV(D), .LINE_FRONT(F),
                     .LINE_BACK(B), .FIELD_GAP(G), .MEM_AW(AW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_data(mem_data), .video_frame_valid(fv), .video_line_valid(lv),
    .video_data_valid(dvs), .video_data_out(dout), .video_address(vaddr),
    .frame_done(done));

  always #5 clk = ~clk;

  logic [7:0] mem [NPIX];
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Frame-store read port: the addressed byte appears only in the clock after mem_rd.
  bit rd_pend = 0;
  int pend_a = 0;
  always @(negedge clk) begin
    if (rd_pend && pend_a < NPIX) mem_data = mem[pend_a];
    else                          mem_data = 8'($urandom);
    rd_pend = (mem_rd === 1'b1);
    pend_a  = int'(mem_addr);
  end

  // Model: position m_t inside the running frame.
  bit m_run = 0;
  int m_t = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 0; m_t = 0;
    end else if (!m_run) begin
      if (enable) begin m_run = 1; m_t = 0; end
    end else if (m_t == FRAME - 1) begin
      if (enable) m_t = 0; else m_run = 0;
    end else m_t++;
  end

  logic [7:0]  h_d = 0;
  logic [19:0] h_a = 0;
  always @(negedge clk) begin
    int fld, tf, row, tl, col, s, lin;
    bit efv, elv, erd, edv, edn;
    efv = 0; elv = 0; erd = 0; edv = 0; edn = 0;
    fld = 0; row = 0; col = 0; s = 0; lin = 0; tf = 0; tl = 0;
    if (!m_run) begin
      h_d = 0; h_a = 0;
    end else begin
      fld = m_t / FL; tf = m_t % FL;
      efv = tf < FP;
      row = tf / LP; tl = tf % LP;
      elv = efv && tl >= F && tl < F + H * D;
      if (elv) begin
        col = (tl - F) / D; s = (tl - F) % D;
        erd = (s == 0); edv = (s == 2);
        lin = fld * V * H + row * H + col;
      end
      edn = (m_t == FL + FP);
      if (edv) begin
        h_d = mem[lin];
        h_a = {row[8:0], fld[0], col[9:0]};
      end
    end
    chk("frame_valid", 32'(fv), 32'(efv));
    chk("line_valid", 32'(lv), 32'(elv));
    chk("data_valid", 32'(dvs), 32'(edv));
    chk("mem_rd", 32'(mem_rd), 32'(erd));
    chk("frame_done", 32'(done), 32'(edn));
    chk("data_out", 32'(dout), 32'(h_d));
    chk("video_address", 32'(vaddr), 32'(h_a));
    if (erd || !m_run) chk("mem_addr", 32'(mem_addr), 32'(lin));
  end

  // Run statistics observed directly on the DUT outputs.
  int dv_cnt = 0, done_cnt = 0, lv_run = 0, fv_run = 0, lo_run = 0;
  int last_lv = 0, last_hi = 0, last_lo = 0, last_per = 0;
  int rise_cyc = -1, rise_fvid = -1, fvid = 0, cyc = 0, dv_bad = 0;
  bit lv_p = 0, fv_p = 0;
  logic [7:0]  dv_vals[$];
  logic [19:0] dv_adrs[$];
  always @(negedge clk) begin
    cyc++;
    if (fv === 1'b1 && !fv_p) begin last_lo = lo_run; fv_run = 0; fvid++; end
    if (fv !== 1'b1 && fv_p) begin last_hi = fv_run; lo_run = 0; end
    if (fv === 1'b1) fv_run++; else lo_run++;
    if (lv === 1'b1 && !lv_p) begin
      if (rise_fvid == fvid) last_per = cyc - rise_cyc;
      rise_cyc = cyc; rise_fvid = fvid; lv_run = 0;
    end
    if (lv !== 1'b1 && lv_p) last_lv = lv_run;
    if (lv === 1'b1) lv_run++;
    if (dvs === 1'b1) begin
      dv_cnt++;
      dv_vals.push_back(dout);
      dv_adrs.push_back(vaddr);
      if (lv !== 1'b1 || fv !== 1'b1 || (lv_run - 1) % D != 2) dv_bad++;
    end
    if (done === 1'b1) done_cnt++;
    lv_p = (lv === 1'b1); fv_p = (fv === 1'b1);
  end

  task automatic wait_done(input int n, input int lim);
    int k = 0;
    while (done_cnt < n && k < lim) begin @(negedge clk); k++; end
    if (done_cnt < n) chk("timeout frame_done", 32'(done_cnt), 32'(n));
    @(negedge clk); #1;
  endtask

  task automatic wait_t(input int tgt, input int lim);
    int k = 0;
    while (!(m_run && m_t == tgt) && k < lim) begin @(negedge clk); k++; end
    if (!(m_run && m_t == tgt)) chk("timeout position", 32'(m_t), 32'(tgt));
  endtask

  task automatic wait_idle(input int lim);
    int k = 0;
    while (m_run && k < lim) begin @(negedge clk); k++; end
    if (m_run) chk("timeout idle", 32'(m_run), 32'd0);
  endtask

  task automatic wait_dv(input int base, input int lim);
    int k = 0;
    while (dv_vals.size() <= base && k < lim) begin @(negedge clk); k++; end
    if (dv_vals.size() <= base) chk("timeout data_valid", 32'(dv_vals.size()), 32'(base + 1));
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " frame_valid"}, 32'(fv), 0);
    chk({nm, " line_valid"}, 32'(lv), 0);
    chk({nm, " data_valid"}, 32'(dvs), 0);
    chk({nm, " mem_rd"}, 32'(mem_rd), 0);
    chk({nm, " mem_addr"}, 32'(mem_addr), 0);
    chk({nm, " data_out"}, 32'(dout), 0);
    chk({nm, " video_address"}, 32'(vaddr), 0);
    chk({nm, " frame_done"}, 32'(done), 0);
  endtask

  initial begin
    int base, n0;
    for (int i = 0; i < NPIX; i++) mem[i] = 8'(i);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b1;

    // Two back-to-back frames, memory[i]=i.
    wait_done(2, 600);
    chk("strobes in 2 frames", 32'(dv_cnt), 32'd48);
    chk("frame_done count", 32'(done_cnt), 32'd2);
    for (int i = 0; i < 48; i++) begin
      int p;
      p = i % 24;
      chk("pixel value", (i < dv_vals.size()) ? 32'(dv_vals[i]) : 32'hffff_ffff, 32'(p));
      chk("pixel address", (i < dv_adrs.size()) ? 32'(dv_adrs[i]) : 32'hffff_ffff,
          32'((((p % 12) / 4) << 11) | ((p / 12) << 10) | (p % 4)));
    end
    chk("line_valid width", 32'(last_lv), 32'd16);
    chk("line period", 32'(last_per), 32'd27);
    chk("frame_valid high", 32'(last_hi), 32'd81);
    chk("frame_valid low gap", 32'(last_lo), 32'd10);
    chk("strobe slot offset", 32'(dv_bad), 32'd0);

    // Enable dropped during field 0 row 1: the frame still completes.
    wait_t(LP + 3, 400);
    enable = 1'b0;
    wait_done(3, 400);
    wait_idle(200);
    repeat (5) @(negedge clk);
    #1;
    chk("strobes after enable drop", 32'(dv_cnt - 48), 32'd24);
    chk_all_zero("idle");
    for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
    base = dv_vals.size();
    enable = 1'b1;
    wait_dv(base, 200);
    chk("restart first address", 32'(dv_adrs[base]), 32'd0);
    chk("restart first data", 32'(dv_vals[base]), 32'(mem[0]));

    // Asynchronous reset in the middle of a field 1 active line.
    wait_t(FL + LP + F + 5, 400);
    #2 rst = 1'b1;
    #1 chk_all_zero("async reset");
    @(negedge clk);
    @(negedge clk);
    base = dv_vals.size();
    rst = 1'b0;
    wait_dv(base, 200);
    chk("post-reset first address", 32'(dv_adrs[base]), 32'd0);
    chk("post-reset first data", 32'(dv_vals[base]), 32'(mem[0]));
    n0 = done_cnt;
    wait_done(n0 + 1, 400);
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/video_stream_gen.md
Name: video_stream_gen

Overview:
- Hardware video source that drives the interlaced capture interface consumed by the processing blocks.
- Interface signals: frame_valid, line_valid, data_valid strobe, 8-bit pixel, 20-bit {row, field, col} address.
- Pixels are fetched from a linear frame-store read port.
- Each frame is emitted as two fields (field 0 then field 1) of V_ACTIVE lines × H_ACTIVE pixels, with the same porch and gap timing the processing chain is characterised against.

Parameters:
- H_ACTIVE, 702, pixels per line
- V_ACTIVE, 288, lines per field
- PIX_DIV, 8, clocks per pixel slot (min 3)
- LINE_FRONT, 1500, clocks from line start to line_valid rise
- LINE_BACK, 1884, clocks after line_valid fall to next line start
- FIELD_GAP, 100000, clocks with frame_valid low between fields and between frames
- MEM_AW, 19, frame-store address width (must hold 2·V_ACTIVE·H_ACTIVE − 1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  level; start/continue emitting frames
- mem_rd  out  1  one-clock frame-store read strobe
- mem_addr  out  MEM_AW  linear pixel index
- mem_data  in  8  read data, valid exactly 1 clock after mem_rd
- video_frame_valid  out  1  high for a whole field
- video_line_valid  out  1  high for a line's active pixel slots
- video_data_valid  out  1  one-clock pixel strobe
- video_data_out  out  8  pixel value
- video_address  out  20  {row[8:0], field, col[9:0]}
- frame_done  out  1  one-clock pulse after field 1 completes

Behaviour:
- Reset (async; every state):
  - All outputs 0; FSM → IDLE; row/col/field/linear/slot counters cleared.
  - Reset mid-line aborts immediately; no partial-line completion.
- FSM states: IDLE, FRONT, ACTIVE, BACK, GAP.
- IDLE:
  - When enable=1, next clock → FRONT with field=0, row=0, linear=0.
  - video_frame_valid rises on entry to FRONT of row 0.
- FRONT:
  - Lasts LINE_FRONT clocks, then → ACTIVE with col=0, slot=0.
- ACTIVE:
  - Lasts H_ACTIVE·PIX_DIV clocks; video_line_valid=1 for exactly those clocks.
  - Pixel slot, slot cycle 0: mem_rd=1, mem_addr=linear.
  - Slot cycle 1: mem_data captured.
  - Slot cycle 2: video_data_out=captured byte, video_address={row,field,col}, and video_data_valid=1 (this cycle only).
  - Data and address hold until the next slot's cycle 2; they are not cleared at line end.
  - End of slot: col+1 and linear+1.
  - After slot col=H_ACTIVE−1 → BACK.
- BACK:
  - Lasts LINE_BACK clocks.
  - Then, if row<V_ACTIVE−1: row+1 → FRONT.
  - Otherwise field ends: video_frame_valid falls → GAP.
- GAP:
  - Lasts FIELD_GAP clocks.
  - After field 0: field=1, row=0 → FRONT; linear continues (=V_ACTIVE·H_ACTIVE).
  - After field 1: frame_done pulses on the first GAP clock.
    - At GAP end, enable=1 → new frame (field 0, linear=0).
    - enable=0 → IDLE.
- enable:
  - Sampled only at IDLE and at the end of a frame's final GAP.
  - Deassertion mid-frame does not truncate the frame.
- Field period: V_ACTIVE·(LINE_FRONT + H_ACTIVE·PIX_DIV + LINE_BACK) clocks of frame_valid high (defaults: 2 592 000).
- Address widths: video_address row is row[8:0], col is col[9:0], zero-extended. Linear index wraps only via the frame restart, never arithmetically.
- Timing of data strobe: video_data_valid never asserts outside line_valid; line_valid never outside frame_valid.

Test Plan:
- Small params (H_ACTIVE=4, V_ACTIVE=3, PIX_DIV=4, LINE_FRONT=5, LINE_BACK=6, FIELD_GAP=10), memory[i]=i, enable held 1 → required response:
  - 24 data_valid strobes per frame, values 0..23 in order.
  - Addresses {row,field,col} match the row/field/col of each pixel.
  - frame_done once per frame.
- Same params → required per-line timing:
  - line_valid high exactly 16 clocks per line.
  - line period 27 clocks.
  - frame_valid high 81 clocks, low 10 between fields.
  - data_valid at slot offset 2 (clocks 2, 6, 10, 14 of each line_valid window).
- mem_data changed on every clock except the capture cycle → video_data_out equals the byte present one clock after mem_rd and is stable through the slot.
- enable dropped during field 0 row 1 → frame completes (all 24 pixels, frame_done), then IDLE with all outputs 0. Re-raise enable → next frame restarts at linear 0, field 0.
- rst asserted mid-ACTIVE of field 1 (asynchronous, between clock edges) → outputs 0 immediately. After release with enable=1, first pixel is address 0, data memory[0].
- Default params, 1 frame → required counts:
  - 404 352 data_valid strobes.
  - Last mem_addr 404 351; last video_address {287,1,701}.
  - frame_valid high 2 592 000 clocks per field.
